adpcm_rom_arbiter: RTL and testbench
====================================

// Module: adpcm_rom_arbiter
// PURPOSE
// FPGA-side ROM controller behind the YM2610 ADPCM-A (rad/rmpx/roe) and ADPCM-B (pad/pmpx/poe) buses.
// Demultiplexes both 24-bit address phases and queues one read per channel.
// Arbitrates a single shared memory port (B over A) and returns data on rad/pad while roe/poe are low.
// Top level owns the tristate pads; this block exposes _out/_oe pairs.
// PARAMETERS
// A_BASE      25'h0000000  offset added to ADPCM-A byte address
// B_BASE      25'h1000000  offset added to ADPCM-B byte address
// SYNC_STAGES 2            flops per async YM2610 input (>=2)
// PORTS
// clk        in   1   system clock, >= 32 MHz; all YM2610 inputs are async to it
// ic_n       in   1   reset, asynchronous, active-low
// rad_in     in   8   ADPCM-A mux address bus (sampled)
// ra9_8      in   2   ADPCM-A address bits; [9:8] in low phase, [19:18] in high phase
// ra23_20    in   4   ADPCM-A address bits [23:20], high phase only
// rmpx, roe  in   1   ADPCM-A mux strobe / output enable (active low)
// pad_in     in   8   ADPCM-B mux address bus
// pa11_8     in   4   ADPCM-B address bits; [11:8] in low phase, [23:20] in high phase
// pmpx, poe  in   1   ADPCM-B mux strobe / output enable (active low)
// rad_out    out  8   data toward rad;  rad_oe out 1  drive enable
// pad_out    out  8   data toward pad;  pad_oe out 1  drive enable
// mem_req    out  1   memory request; held with mem_addr until mem_ready
// mem_addr   out  25  byte address = base + 24-bit channel address
// mem_ready  in   1   request accepted this cycle
// mem_rvalid in   1   read data valid, in order, one per accepted request
// mem_rdata  in   8   read data
// a_late, b_late      out 1  1-cycle pulse: oe fell before channel data valid
// a_overrun, b_overrun out 1 1-cycle pulse: new mpx rise before previous read finished
// BEHAVIOUR
// - Reset values: all outputs 0, channel FSMs IDLE, arbiter IDLE, data regs 8'h00.
// - Inputs pass SYNC_STAGES flops. Edges are detected on the synchronised strobe. Bus values are sampled on the edge-detect cycle.
// - Channel FSM (A and B identical): IDLE -mpx rise-> LOW (latch low bytes) -mpx fall-> PEND (latch high bytes)
//   -granted-> ISSUED -mem_rvalid-> VALID -oe rise-> IDLE.
// - A addr = {ra23_20, ra9_8(hi), rad(hi), ra9_8(lo), rad(lo)}; B addr = {pa11_8(hi), pad(hi), pa11_8(lo), pad(lo)}.
// - Arbiter: one outstanding request. IDLE: if B PEND, grant B; else if A PEND, grant A.
//   Assert mem_req and hold it until mem_ready, then WAIT until mem_rvalid, then IDLE. Same-cycle re-grant is allowed.
// - Request latency: mem_req rises 1 clk after the PEND entry when the arbiter is idle.
// - rdata is stored in the owning channel's data reg in the mem_rvalid cycle.
// - x_oe = 1 while synced oe low AND channel VALID; x_out = data reg.
//   If oe falls while not VALID: pulse x_late, keep oe deasserted, and abort any read still in PEND.
//   A read already ISSUED completes, but its data is discarded.
// - mpx rise in any state but IDLE: pulse x_overrun and restart at LOW.
//   An ISSUED read keeps its arbiter slot; its response is dropped through a per-request channel+epoch tag.
// - Simultaneous A and B PEND: B wins. A is served next (B rate <= 1 per 12 B-states, so A cannot starve).
// - mem_addr wraps mod 2^25 (base add carries are discarded).
// - ic_n low at any time: immediate return to reset values; mem_rvalid arriving after reset is ignored (no WAIT).
// STRUCTURE
// - Package adpcm_rom_pkg: chan_state_t enum, arb_state_t enum, ADDR_W=24, MEM_AW=25.
// - Sub-module adpcm_bus_capture, instantiated twice (A and B), parameterised for the low/high field split.
//   It holds the synchroniser, edge detect, channel FSM, data reg and oe logic.
// - Top holds the arbiter FSM, tag and base add.
// TESTING
// 1. A cycle addr 24'h123456: lo rad=56 ra9_8=0, hi rad=8D ra9_8=0 ra23_20=1
//    -> mem_addr=25'h0123456; rdata=3C -> rad_oe during roe low, rad_out=3C.
// 2. B cycle addr 24'hABCDEF: lo pad=EF pa11_8=D, hi pad=BC pa11_8=A
//    -> mem_addr=25'h1ABCDEF; rdata=A5 -> pad_out=A5 while poe low.
// 3. A and B reach PEND the same clk, mem_ready tied 1 -> B request first, A next.
//    Each channel gets its own data; no late pulse.
// 4. Hold mem_ready low until after roe falls -> a_late pulses once, rad_oe stays 0.
//    The late data does not drive on the next cycle.
// 5. Second rmpx rise while A ISSUED -> a_overrun pulse.
//    Stale rvalid is discarded; the new address (24'h000001) is read correctly.
// 6. Assert ic_n low while in WAIT, then deliver mem_rvalid -> all outputs 0, no data latched.
//    The next A cycle works normally.

Source files
------------

// File: rtl/adpcm_rom_pkg.sv
// Shared types and widths for the YM2610 ADPCM ROM controller.
package adpcm_rom_pkg;

  localparam int ADDR_W = 24;
  localparam int MEM_AW = 25;

  typedef enum logic [2:0] {
    CH_IDLE   = 3'd0,
    CH_LOW    = 3'd1,
    CH_PEND   = 3'd2,
    CH_ISSUED = 3'd3,
    CH_VALID  = 3'd4
  } chan_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  // Channel byte address relocated into the shared space; carries out of bit 24 are dropped.
  function automatic logic [MEM_AW-1:0] mem_addr_f(input logic [MEM_AW-1:0] base,
                                                   input logic [ADDR_W-1:0] addr);
    return base + {1'b0, addr};
  endfunction

endpackage

// File: rtl/adpcm_bus_capture.sv
// One YM2610 ROM channel: input synchronisers, mux address capture, read-cycle FSM
// and the data/enable pair driven back onto the multiplexed bus.
module adpcm_bus_capture
  import adpcm_rom_pkg::*;
#(
  parameter int EXT_W       = 6,
  parameter int LO_EXT_W    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_bus,
  input  logic [EXT_W-1:0]  i_ext,
  input  logic              i_mpx,
  input  logic              i_oe_n,
  input  logic              i_grant,
  input  logic              i_rvalid,
  input  logic              i_rtag_epoch,
  input  logic [7:0]        i_rdata,
  output logic              o_pend,
  output logic              o_epoch,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_out,
  output logic              o_oe,
  output logic              o_late,
  output logic              o_overrun
);

  logic [SYNC_STAGES-1:0][7:0]       r_bus_sync;
  logic [SYNC_STAGES-1:0][EXT_W-1:0] r_ext_sync;
  logic [SYNC_STAGES-1:0]            r_mpx_sync;
  logic [SYNC_STAGES-1:0]            r_oe_sync;
  logic                              r_mpx_q;
  logic                              r_oe_q;

  chan_state_t              r_state;
  chan_state_t              w_state_nxt;
  logic [LO_EXT_W+7:0]      r_lo;
  logic [EXT_W+7:0]         r_hi;
  logic [7:0]               r_data;
  logic                     r_epoch;
  logic                     r_oe;
  logic                     r_late;
  logic                     r_ovr;

  logic [7:0]       w_bus;
  logic [EXT_W-1:0] w_ext;
  logic             w_mpx, w_oe_n;
  logic             w_mpx_rise, w_mpx_fall, w_oe_fall, w_oe_rise;
  logic             w_latch_lo, w_latch_hi, w_latch_data, w_epoch_tgl, w_late, w_ovr;

  assign w_bus      = r_bus_sync[SYNC_STAGES-1];
  assign w_ext      = r_ext_sync[SYNC_STAGES-1];
  assign w_mpx      = r_mpx_sync[SYNC_STAGES-1];
  assign w_oe_n     = r_oe_sync[SYNC_STAGES-1];
  assign w_mpx_rise = w_mpx & ~r_mpx_q;
  assign w_mpx_fall = ~w_mpx & r_mpx_q;
  assign w_oe_fall  = ~w_oe_n & r_oe_q;
  assign w_oe_rise  = w_oe_n & ~r_oe_q;

  // Synchronisers and edge-detect history; oe idles high so reset produces no edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bus_sync <= {SYNC_STAGES{8'h00}};
      r_ext_sync <= {SYNC_STAGES{{EXT_W{1'b0}}}};
      r_mpx_sync <= {SYNC_STAGES{1'b0}};
      r_oe_sync  <= {SYNC_STAGES{1'b1}};
      r_mpx_q    <= 1'b0;
      r_oe_q     <= 1'b1;
    end else begin
      r_bus_sync <= {r_bus_sync[SYNC_STAGES-2:0], i_bus};
      r_ext_sync <= {r_ext_sync[SYNC_STAGES-2:0], i_ext};
      r_mpx_sync <= {r_mpx_sync[SYNC_STAGES-2:0], i_mpx};
      r_oe_sync  <= {r_oe_sync[SYNC_STAGES-2:0], i_oe_n};
      r_mpx_q    <= w_mpx;
      r_oe_q     <= w_oe_n;
    end
  end

  // Read-cycle FSM; a new strobe or an early oe always abandons the current cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_latch_lo   = 1'b0;
    w_latch_hi   = 1'b0;
    w_latch_data = 1'b0;
    w_epoch_tgl  = 1'b0;
    w_late       = 1'b0;
    w_ovr        = 1'b0;
    if (w_mpx_rise) begin
      w_state_nxt = CH_LOW;
      w_latch_lo  = 1'b1;
      w_epoch_tgl = 1'b1;
      w_ovr       = (r_state != CH_IDLE);
    end else if (w_oe_fall && (r_state != CH_VALID)) begin
      w_state_nxt = CH_IDLE;
      w_epoch_tgl = 1'b1;
      w_late      = 1'b1;
    end else begin
      case (r_state)
        CH_IDLE:   w_state_nxt = CH_IDLE;
        CH_LOW: begin
          if (w_mpx_fall) begin
            w_state_nxt = CH_PEND;
            w_latch_hi  = 1'b1;
          end else begin
            w_state_nxt = CH_LOW;
          end
        end
        CH_PEND: begin
          if (i_grant) w_state_nxt = CH_ISSUED;
          else         w_state_nxt = CH_PEND;
        end
        CH_ISSUED: begin
          if (i_rvalid && (i_rtag_epoch == r_epoch)) begin
            w_state_nxt  = CH_VALID;
            w_latch_data = 1'b1;
          end else begin
            w_state_nxt = CH_ISSUED;
          end
        end
        CH_VALID: begin
          if (w_oe_rise) w_state_nxt = CH_IDLE;
          else           w_state_nxt = CH_VALID;
        end
        default:   w_state_nxt = CH_IDLE;
      endcase
    end
  end

  // Channel state, captured address halves, data register and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= CH_IDLE;
      r_lo    <= {(LO_EXT_W+8){1'b0}};
      r_hi    <= {(EXT_W+8){1'b0}};
      r_data  <= 8'h00;
      r_epoch <= 1'b0;
      r_oe    <= 1'b0;
      r_late  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_lo)   r_lo    <= {w_ext[LO_EXT_W-1:0], w_bus};
      if (w_latch_hi)   r_hi    <= {w_ext, w_bus};
      if (w_latch_data) r_data  <= i_rdata;
      if (w_epoch_tgl)  r_epoch <= ~r_epoch;
      r_oe   <= (w_state_nxt == CH_VALID) && !w_oe_n;
      r_late <= w_late;
      r_ovr  <= w_ovr;
    end
  end

  assign o_pend    = (r_state == CH_PEND);
  assign o_epoch   = r_epoch;
  assign o_addr    = {r_hi, r_lo};
  assign o_out     = r_data;
  assign o_oe      = r_oe;
  assign o_late    = r_late;
  assign o_overrun = r_ovr;

endmodule

// File: rtl/adpcm_rom_arbiter.sv
// YM2610 ADPCM-A/B ROM controller: two bus capture channels sharing one memory port,
// ADPCM-B having priority, one request outstanding at a time.
module adpcm_rom_arbiter
  import adpcm_rom_pkg::*;
#(
  parameter logic [MEM_AW-1:0] A_BASE      = 25'h0000000,
  parameter logic [MEM_AW-1:0] B_BASE      = 25'h1000000,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_ic_n,
  input  logic [7:0]        i_rad_in,
  input  logic [1:0]        i_ra9_8,
  input  logic [3:0]        i_ra23_20,
  input  logic              i_rmpx,
  input  logic              i_roe,
  input  logic [7:0]        i_pad_in,
  input  logic [3:0]        i_pa11_8,
  input  logic              i_pmpx,
  input  logic              i_poe,
  output logic [7:0]        o_rad_out,
  output logic              o_rad_oe,
  output logic [7:0]        o_pad_out,
  output logic              o_pad_oe,
  output logic              o_mem_req,
  output logic [MEM_AW-1:0] o_mem_addr,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_a_late,
  output logic              o_b_late,
  output logic              o_a_overrun,
  output logic              o_b_overrun
);

  arb_state_t        r_arb_state;
  arb_state_t        w_arb_nxt;
  logic              r_mem_req;
  logic [MEM_AW-1:0] r_mem_addr;
  logic              r_tag_b;
  logic              r_tag_epoch;

  logic              w_a_pend, w_b_pend, w_a_epoch, w_b_epoch;
  logic [ADDR_W-1:0] w_a_addr, w_b_addr;
  logic              w_grant_a, w_grant_b, w_slot_free;
  logic              w_rvalid_a, w_rvalid_b;

  // The tag routes each response back to the channel and cycle that asked for it.
  assign w_rvalid_a = (r_arb_state == ARB_WAIT) & i_mem_rvalid & ~r_tag_b;
  assign w_rvalid_b = (r_arb_state == ARB_WAIT) & i_mem_rvalid &  r_tag_b;

  adpcm_bus_capture #(.EXT_W(6), .LO_EXT_W(2), .SYNC_STAGES(SYNC_STAGES)) u_cap_a (
    .i_clk(i_clk), .i_rst_n(i_ic_n), .i_bus(i_rad_in), .i_ext({i_ra23_20, i_ra9_8}),
    .i_mpx(i_rmpx), .i_oe_n(i_roe), .i_grant(w_grant_a), .i_rvalid(w_rvalid_a),
    .i_rtag_epoch(r_tag_epoch), .i_rdata(i_mem_rdata), .o_pend(w_a_pend),
    .o_epoch(w_a_epoch), .o_addr(w_a_addr), .o_out(o_rad_out), .o_oe(o_rad_oe),
    .o_late(o_a_late), .o_overrun(o_a_overrun)
  );

  adpcm_bus_capture #(.EXT_W(4), .LO_EXT_W(4), .SYNC_STAGES(SYNC_STAGES)) u_cap_b (
    .i_clk(i_clk), .i_rst_n(i_ic_n), .i_bus(i_pad_in), .i_ext(i_pa11_8),
    .i_mpx(i_pmpx), .i_oe_n(i_poe), .i_grant(w_grant_b), .i_rvalid(w_rvalid_b),
    .i_rtag_epoch(r_tag_epoch), .i_rdata(i_mem_rdata), .o_pend(w_b_pend),
    .o_epoch(w_b_epoch), .o_addr(w_b_addr), .o_out(o_pad_out), .o_oe(o_pad_oe),
    .o_late(o_b_late), .o_overrun(o_b_overrun)
  );

  // Arbiter next state; the slot frees in the rvalid cycle so a waiting channel is re-granted at once.
  always_comb begin
    w_arb_nxt   = r_arb_state;
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    w_slot_free = 1'b0;
    case (r_arb_state)
      ARB_IDLE: w_slot_free = 1'b1;
      ARB_REQ: begin
        if (i_mem_ready) w_arb_nxt = ARB_WAIT;
        else             w_arb_nxt = ARB_REQ;
      end
      ARB_WAIT: begin
        if (i_mem_rvalid) begin
          w_arb_nxt   = ARB_IDLE;
          w_slot_free = 1'b1;
        end else begin
          w_arb_nxt = ARB_WAIT;
        end
      end
      default: w_arb_nxt = ARB_IDLE;
    endcase
    if (w_slot_free && w_b_pend) begin
      w_grant_b = 1'b1;
      w_arb_nxt = ARB_REQ;
    end else if (w_slot_free && w_a_pend) begin
      w_grant_a = 1'b1;
      w_arb_nxt = ARB_REQ;
    end else begin
      w_grant_a = 1'b0;
    end
  end

  // Arbiter state, held request/address and the response tag.
  always_ff @(posedge i_clk or negedge i_ic_n) begin
    if (!i_ic_n) begin
      r_arb_state <= ARB_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= {MEM_AW{1'b0}};
      r_tag_b     <= 1'b0;
      r_tag_epoch <= 1'b0;
    end else begin
      r_arb_state <= w_arb_nxt;
      r_mem_req   <= (w_arb_nxt == ARB_REQ);
      if (w_grant_b) begin
        r_mem_addr  <= mem_addr_f(B_BASE, w_b_addr);
        r_tag_b     <= 1'b1;
        r_tag_epoch <= w_b_epoch;
      end else if (w_grant_a) begin
        r_mem_addr  <= mem_addr_f(A_BASE, w_a_addr);
        r_tag_b     <= 1'b0;
        r_tag_epoch <= w_a_epoch;
      end
    end
  end

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;

endmodule

// File: tb/tb_adpcm_rom_arbiter.sv
// Directed bench for adpcm_rom_arbiter: YM2610-style address phases, a hand-driven
// memory port and hand-computed expected addresses, data and pulse counts.
module tb_adpcm_rom_arbiter;

  logic        clk = 1'b0;
  logic        ic_n;
  logic [7:0]  rad_in, pad_in, mem_rdata;
  logic [1:0]  ra9_8;
  logic [3:0]  ra23_20, pa11_8;
  logic        rmpx, roe, pmpx, poe, mem_ready, mem_rvalid;
  logic [7:0]  rad_out, pad_out;
  logic        rad_oe, pad_oe, mem_req;
  logic [24:0] mem_addr;
  logic        a_late, b_late, a_ovr, b_ovr;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cnt_a_late = 0, cnt_b_late = 0, cnt_a_ovr = 0, cnt_b_ovr = 0, cnt_rad_oe = 0;
  int   base_late, base_ovr, base_oe;
  logic ready_tie = 1'b0;

  adpcm_rom_arbiter dut (
    .i_clk(clk), .i_ic_n(ic_n), .i_rad_in(rad_in), .i_ra9_8(ra9_8), .i_ra23_20(ra23_20),
    .i_rmpx(rmpx), .i_roe(roe), .i_pad_in(pad_in), .i_pa11_8(pa11_8), .i_pmpx(pmpx),
    .i_poe(poe), .o_rad_out(rad_out), .o_rad_oe(rad_oe), .o_pad_out(pad_out),
    .o_pad_oe(pad_oe), .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ready(mem_ready),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .o_a_late(a_late), .o_b_late(b_late),
    .o_a_overrun(a_ovr), .o_b_overrun(b_ovr)
  );

  always #5 clk = ~clk;

  // Pulse and drive-enable counters sampled mid-cycle.
  always @(negedge clk) begin
    if (a_late) cnt_a_late++;
    if (b_late) cnt_b_late++;
    if (a_ovr)  cnt_a_ovr++;
    if (b_ovr)  cnt_b_ovr++;
    if (rad_oe) cnt_rad_oe++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic a_lo(input logic [7:0] b, input logic [1:0] x);
    rad_in = b; ra9_8 = x; rmpx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic a_hi(input logic [7:0] b, input logic [1:0] x, input logic [3:0] t);
    rad_in = b; ra9_8 = x; ra23_20 = t; rmpx = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic b_lo(input logic [7:0] b, input logic [3:0] x);
    pad_in = b; pa11_8 = x; pmpx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic b_hi(input logic [7:0] b, input logic [3:0] x);
    pad_in = b; pa11_8 = x; pmpx = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_req(input string tag, input logic [24:0] exp_addr);
    int k = 0;
    while (!mem_req && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, "_addr"}, {7'd0, mem_addr}, {7'd0, exp_addr});
  endtask

  task automatic serve(input logic [7:0] data);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = ready_tie; mem_rvalid = 1'b1; mem_rdata = data;
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  initial begin
    ic_n = 1'b0; rad_in = 8'h00; ra9_8 = 2'd0; ra23_20 = 4'd0; rmpx = 1'b0; roe = 1'b1;
    pad_in = 8'h00; pa11_8 = 4'd0; pmpx = 1'b0; poe = 1'b1;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", {7'd0, mem_addr}, 32'd0);
    chk("rst_data", {16'd0, rad_out, pad_out}, 32'd0);
    chk("rst_flags", {26'd0, rad_oe, pad_oe, a_late, b_late, a_ovr, b_ovr}, 32'd0);
    ic_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: ADPCM-A read of 24'h123456
    base_late = cnt_a_late;
    a_lo(8'h56, 2'd0);
    a_hi(8'h8D, 2'd0, 4'h1);
    wait_req("t1", 25'h0123456);
    serve(8'h3C);
    roe = 1'b0;
    repeat (4) @(negedge clk);
    chk("t1_oe", {31'd0, rad_oe}, 32'd1);
    chk("t1_out", {24'd0, rad_out}, 32'h3C);
    roe = 1'b1;
    repeat (4) @(negedge clk);
    chk("t1_oe_off", {31'd0, rad_oe}, 32'd0);
    chk("t1_late", cnt_a_late - base_late, 32'd0);

    // 2: ADPCM-B read of 24'hABCDEF, relocated by B_BASE
    b_lo(8'hEF, 4'hD);
    b_hi(8'hBC, 4'hA);
    wait_req("t2", 25'h1ABCDEF);
    serve(8'hA5);
    poe = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_oe", {31'd0, pad_oe}, 32'd1);
    chk("t2_out", {24'd0, pad_out}, 32'hA5);
    poe = 1'b1;
    repeat (4) @(negedge clk);
    chk("t2_oe_off", {31'd0, pad_oe}, 32'd0);

    // 3: both channels pend together with ready tied high; B is served first
    ready_tie = 1'b1; mem_ready = 1'b1;
    base_late = cnt_a_late + cnt_b_late;
    rad_in = 8'h11; ra9_8 = 2'd0; rmpx = 1'b1;
    pad_in = 8'h22; pa11_8 = 4'd0; pmpx = 1'b1;
    repeat (4) @(negedge clk);
    rad_in = 8'h00; ra23_20 = 4'd0; rmpx = 1'b0;
    pad_in = 8'h00; pmpx = 1'b0;
    repeat (4) @(negedge clk);
    wait_req("t3b", 25'h1000022);
    serve(8'h77);
    wait_req("t3a", 25'h0000011);
    serve(8'h66);
    ready_tie = 1'b0; mem_ready = 1'b0;
    roe = 1'b0; poe = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_a_out", {23'd0, rad_oe, rad_out}, 32'h166);
    chk("t3_b_out", {23'd0, pad_oe, pad_out}, 32'h177);
    chk("t3_late", (cnt_a_late + cnt_b_late) - base_late, 32'd0);
    roe = 1'b1; poe = 1'b1;
    repeat (4) @(negedge clk);

    // 4: memory stalls past roe fall -> one late pulse, data never driven
    base_late = cnt_a_late; base_oe = cnt_rad_oe;
    a_lo(8'h42, 2'd0);
    a_hi(8'h00, 2'd0, 4'h0);
    wait_req("t4", 25'h0000042);
    roe = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_late", cnt_a_late - base_late, 32'd1);
    serve(8'h99);
    repeat (3) @(negedge clk);
    chk("t4_oe_cnt", cnt_rad_oe - base_oe, 32'd0);
    chk("t4_out_kept", {24'd0, rad_out}, 32'h66);
    roe = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_late_once", cnt_a_late - base_late, 32'd1);

    // 5: new rmpx while issued -> overrun, stale response dropped, new address read
    a_lo(8'h33, 2'd0);
    a_hi(8'h00, 2'd0, 4'h0);
    wait_req("t5_old", 25'h0000033);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    base_ovr = cnt_a_ovr; base_late = cnt_a_late;
    a_lo(8'h01, 2'd0);
    mem_rvalid = 1'b1; mem_rdata = 8'hEE;
    @(negedge clk);
    mem_rvalid = 1'b0;
    a_hi(8'h00, 2'd0, 4'h0);
    wait_req("t5_new", 25'h0000001);
    serve(8'h5A);
    roe = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_out", {23'd0, rad_oe, rad_out}, 32'h15A);
    chk("t5_ovr", cnt_a_ovr - base_ovr, 32'd1);
    chk("t5_late", cnt_a_late - base_late, 32'd0);
    roe = 1'b1;
    repeat (4) @(negedge clk);

    // 6: reset while waiting for data, then stray rvalid; next cycle normal
    a_lo(8'h77, 2'd0);
    a_hi(8'h00, 2'd0, 4'h0);
    wait_req("t6_pre", 25'h0000077);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; ic_n = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 8'hC3;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("t6_rst_mem", {6'd0, mem_req, mem_addr}, 32'd0);
    chk("t6_rst_a", {23'd0, rad_oe, rad_out}, 32'd0);
    ic_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_stray", {23'd0, mem_req, rad_out}, 32'd0);
    a_lo(8'hA0, 2'd0);
    a_hi(8'h00, 2'd0, 4'h0);
    wait_req("t6_post", 25'h00000A0);
    serve(8'h81);
    roe = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_out", {23'd0, rad_oe, rad_out}, 32'h181);
    roe = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_oe_off", {31'd0, rad_oe}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
